sb_rdi_cfg_tx_arbiter: RTL

Shares the PHY-to-adapter RDI sideband config path (pl_cfg / pl_cfg_vld) between two requesters:
- remote-die sideband messages forwarded to the adapter (source 0, RX_FWD);
- locally generated PHY register completions (source 1, LOC).

The block is credit-gated by the adapter-side credit counter. It serializes each 64-bit header plus optional 64-bit data into NC-bit beats. It emits one credit-consume pulse per message, and that pulse drives the counter's rising-edge-of-pl_cfg_vld input.

---
 rtl/sb_rdi_cfg_pkg.sv | 28 ++
 rtl/sb_rdi_cfg_tx_arbiter_serializer.sv | 54 +++++
 rtl/sb_rdi_cfg_tx_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/sb_rdi_cfg_pkg.sv
// Shared types and helpers for the RDI sideband config TX arbiter.
package sb_rdi_cfg_pkg;

  localparam int MSG_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef enum logic {
    SRC_RX_FWD = 1'b0,
    SRC_LOC    = 1'b1
  } src_e;

  typedef struct packed {
    logic [MSG_W-1:0] data;
    logic [MSG_W-1:0] hdr;
    logic             has_data;
  } cfg_msg_t;

  // Beats needed for one message: header only, or header plus data.
  function automatic int beats_f(input int nc, input logic has_data);
    return (MSG_W / nc) * (has_data ? 2 : 1);
  endfunction

endpackage

// File: rtl/sb_rdi_cfg_tx_arbiter_serializer.sv
// Holds one captured message and walks it out NC bits at a time, header first.
module sb_rdi_cfg_serializer
  import sb_rdi_cfg_pkg::*;
#(
  parameter int NC = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  cfg_msg_t      i_msg,
  input  logic          i_advance,
  output logic [NC-1:0] o_beat,
  output logic          o_last
);

  localparam int BEATS = MSG_W / NC;
  localparam int CW    = $clog2(2 * BEATS) + 1;

  logic [2*BEATS-1:0][NC-1:0] words_q, words_d;
  logic                       has_data_q, has_data_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]              total;

  assign total  = CW'(beats_f(NC, has_data_q));
  assign o_last = (cnt_q == total - 1'b1);
  // Counter tops out at 2*BEATS-1, so the low CW-1 bits always address a word.
  assign o_beat = words_q[cnt_q[CW-2:0]];

  always_comb begin
    words_d    = words_q;
    has_data_d = has_data_q;
    cnt_d      = cnt_q;
    if (i_load) begin
      words_d    = {i_msg.data, i_msg.hdr};
      has_data_d = i_msg.has_data;
      cnt_d      = '0;
    end else if (i_advance) begin
      cnt_d = o_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      words_q    <= '0;
      has_data_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      words_q    <= words_d;
      has_data_q <= has_data_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/sb_rdi_cfg_tx_arbiter.sv
// Credit-gated two-source arbiter onto the RDI pl_cfg sideband path.
// Define SB_ARB_STRICT_PRIO_EN for fixed RX_FWD priority instead of round robin.
module sb_rdi_cfg_tx_arbiter
  import sb_rdi_cfg_pkg::*;
#(
  parameter int NC = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rx_fwd_vld,
  input  logic [63:0]   i_rx_fwd_hdr,
  input  logic [63:0]   i_rx_fwd_data,
  input  logic          i_rx_fwd_has_data,
  output logic          o_rx_fwd_ack,
  input  logic          i_loc_vld,
  input  logic [63:0]   i_loc_hdr,
  input  logic [63:0]   i_loc_data,
  input  logic          i_loc_has_data,
  output logic          o_loc_ack,
  input  logic          i_adapter_is_full,
  output logic          o_crd_consume,
  output logic [NC-1:0] o_pl_cfg,
  output logic          o_pl_cfg_vld,
  output logic          o_busy
);

  state_e        state_q, state_d;
  src_e          rr_last_q, rr_last_d;
  logic          ack_rx_q, ack_rx_d;
  logic          ack_loc_q, ack_loc_d;
  logic          consume_q, consume_d;
  logic          capture, grant_loc;
  logic          ser_load, ser_adv, ser_last;
  logic [NC-1:0] ser_beat;
  cfg_msg_t      rx_msg, loc_msg, win_msg;

  assign rx_msg  = '{data: i_rx_fwd_data, hdr: i_rx_fwd_hdr, has_data: i_rx_fwd_has_data};
  assign loc_msg = '{data: i_loc_data, hdr: i_loc_hdr, has_data: i_loc_has_data};

`ifdef SB_ARB_STRICT_PRIO_EN
  assign grant_loc = i_loc_vld & ~i_rx_fwd_vld;
`else
  // On contention the source that did not win last time goes next.
  assign grant_loc = i_loc_vld & (~i_rx_fwd_vld | (rr_last_q == SRC_RX_FWD));
`endif

  assign win_msg = grant_loc ? loc_msg : rx_msg;
  assign capture = (state_q == IDLE) & (i_rx_fwd_vld | i_loc_vld) & ~i_adapter_is_full;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    ack_rx_d  = 1'b0;
    ack_loc_d = 1'b0;
    consume_d = 1'b0;
    ser_load  = 1'b0;
    ser_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          ser_load  = 1'b1;
          ack_loc_d = grant_loc;
          ack_rx_d  = ~grant_loc;
          consume_d = 1'b1;
`ifndef SB_ARB_STRICT_PRIO_EN
          rr_last_d = grant_loc ? SRC_LOC : SRC_RX_FWD;
`endif
          state_d   = SEND;
        end
      end
      SEND: begin
        ser_adv = 1'b1;
        if (ser_last) state_d = GAP;
      end
      // One dead cycle forces a fresh pl_cfg_vld rising edge per message.
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rr_last_q <= SRC_LOC;
      ack_rx_q  <= 1'b0;
      ack_loc_q <= 1'b0;
      consume_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      ack_rx_q  <= ack_rx_d;
      ack_loc_q <= ack_loc_d;
      consume_q <= consume_d;
    end
  end

  sb_rdi_cfg_serializer #(.NC(NC)) u_ser (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (ser_load),
    .i_msg     (win_msg),
    .i_advance (ser_adv),
    .o_beat    (ser_beat),
    .o_last    (ser_last)
  );

  assign o_pl_cfg_vld  = (state_q == SEND);
  assign o_pl_cfg      = o_pl_cfg_vld ? ser_beat : '0;
  assign o_busy        = (state_q != IDLE);
  assign o_rx_fwd_ack  = ack_rx_q;
  assign o_loc_ack     = ack_loc_q;
  assign o_crd_consume = consume_q;

endmodule
